// File: rtl/cordic_pkg.sv
// +--------------------------------------------------------------------------+
// | cordic_pkg : shared constants and helpers for the cosine stream wrapper  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package cordic_pkg;

  localparam int DATA_W         = 32;
  localparam int CORDIC_LATENCY = 34;
  localparam int STAT_W         = 32;

  localparam logic [DATA_W-1:0] FP_ONE  = 32'h3F800000;
  localparam logic [DATA_W-1:0] FP_ZERO = 32'h00000000;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_result_fifo.sv
// +--------------------------------------------------------------------------+
// | cordic_result_fifo : in-order result buffer, first-word fall-through     |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cordic_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [0:(1<<IW)-1];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_rdata;
  logic             w_pop_ok;
  logic [PW-1:0]    w_wr_next;
  logic [PW-1:0]    w_rd_next;

  assign count     = r_wr_ptr - r_rd_ptr;
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (count == PW'(DEPTH));
  assign rdata     = r_rdata;
  assign w_pop_ok  = pop & ~empty;
  assign w_wr_next = r_wr_ptr + PW'(push);
  assign w_rd_next = r_rd_ptr + PW'(w_pop_ok);

  // Head register tracks the entry that will sit at the read pointer after
  // this edge; a push landing on that slot bypasses the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else begin
      assert (!(push && full && !w_pop_ok));
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (w_wr_next == w_rd_next)
        r_rdata <= '0;
      else if (push && (r_wr_ptr == w_rd_next))
        r_rdata <= wdata;
      else
        r_rdata <= r_mem[w_rd_next[IW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      r_mem[r_wr_ptr[IW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/cordic_stream_wrap.sv
// +--------------------------------------------------------------------------+
// | cordic_stream_wrap : valid/ready wrapper with tag pipeline and credits   |
// |                      for a fixed-latency cosine core.                     |
// | Option             : CORDIC_WRAP_STATS_EN adds saturating stat counters. |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cordic_stream_wrap #(
  parameter int DATA_W     = cordic_pkg::DATA_W,
  parameter int LATENCY    = cordic_pkg::CORDIC_LATENCY,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] core_theta,
  input  logic [DATA_W-1:0] core_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef CORDIC_WRAP_STATS_EN
  ,
  output logic [cordic_pkg::STAT_W-1:0] stat_ops,
  output logic [cordic_pkg::STAT_W-1:0] stat_in_stall,
  output logic [cordic_pkg::STAT_W-1:0] stat_out_stall
`endif
);

  import cordic_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [LATENCY-1:0] r_tag;
  logic               r_tag_out;
  logic [CW-1:0]      r_outstanding;
  logic               w_acc;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [CW-1:0]      w_count;

  assign core_theta = in_data;
  assign in_ready   = (r_outstanding < CW'(FIFO_DEPTH)) & ~flush;
  assign w_acc      = in_valid & in_ready;
  assign out_valid  = ~w_empty;
  assign w_pop      = out_valid & out_ready & ~flush;

  // r_tag_out marks the cycle in which core_result holds a tagged op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag         <= '0;
      r_tag_out     <= 1'b0;
      r_outstanding <= '0;
    end else if (flush) begin
      r_tag         <= '0;
      r_tag_out     <= 1'b0;
      r_outstanding <= '0;
    end else begin
      assert (r_outstanding <= CW'(FIFO_DEPTH));
      assert (r_outstanding >= w_count);
      assert (!(w_full && r_tag_out && !w_pop));
      r_tag     <= (r_tag << 1) | LATENCY'(w_acc);
      r_tag_out <= r_tag[LATENCY-1];
      case ({w_acc, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  cordic_result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (r_tag_out),
    .wdata   (core_result),
    .pop     (w_pop),
    .rdata   (out_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

`ifdef CORDIC_WRAP_STATS_EN
  logic [STAT_W-1:0] r_stat_ops;
  logic [STAT_W-1:0] r_stat_in_stall;
  logic [STAT_W-1:0] r_stat_out_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_ops       <= '0;
      r_stat_in_stall  <= '0;
      r_stat_out_stall <= '0;
    end else if (flush) begin
      r_stat_ops       <= '0;
      r_stat_in_stall  <= '0;
      r_stat_out_stall <= '0;
    end else begin
      if (w_acc)                   r_stat_ops       <= sat_inc(r_stat_ops);
      if (in_valid && !in_ready)   r_stat_in_stall  <= sat_inc(r_stat_in_stall);
      if (out_valid && !out_ready) r_stat_out_stall <= sat_inc(r_stat_out_stall);
    end
  end

  assign stat_ops       = r_stat_ops;
  assign stat_in_stall  = r_stat_in_stall;
  assign stat_out_stall = r_stat_out_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cordic_stream_wrap.sv
// Scoreboard bench for cordic_stream_wrap with a ~theta delay-line stub core.
`default_nettype none

module tb_cordic_stream_wrap;

  localparam int LAT   = 34;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, core_theta, core_result, out_data;

`ifdef CORDIC_WRAP_STATS_EN
  logic [31:0] stat_ops, stat_in_stall, stat_out_stall;
`endif

  cordic_stream_wrap #(.DATA_W(32), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_theta  (core_theta),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef CORDIC_WRAP_STATS_EN
    ,
    .stat_ops       (stat_ops),
    .stat_in_stall  (stat_in_stall),
    .stat_out_stall (stat_out_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stub core: result of the op sampled at edge t is held after edge t+LAT.
  logic [31:0] stub [0:LAT];
  always @(posedge clk) begin
    stub[0] <= ~core_theta;
    for (int k = 1; k <= LAT; k++) stub[k] <= stub[k-1];
  end
  assign core_result = stub[LAT];

  typedef struct {
    logic [31:0] d;
    longint      avail;
  } exp_t;

  exp_t   exp_q[$];
  int     model_out = 0;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: credit count = accepted minus popped; each accepted
  // operand becomes ~theta, visible 35 edges after acceptance, in order.
  always @(negedge clk) begin
    logic exp_rdy, exp_vld;
    if (!reset_n) begin
      exp_q.delete();
      model_out = 0;
    end else begin
      exp_rdy = (model_out < DEPTH) && !flush;
      exp_vld = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
      if (exp_vld) check("out_data", out_data, exp_q[0].d);
      if (flush) begin
        exp_q.delete();
        model_out = 0;
      end else begin
        if (exp_vld && out_ready) begin
          void'(exp_q.pop_front());
          model_out--;
        end
        if (in_valid && exp_rdy) begin
          exp_q.push_back('{d: ~in_data, avail: cyc + LAT + 2});
          model_out++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() > 0) && n < 400) begin
      step();
      n++;
    end
    n_vec++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL drain: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic single_op(input string nm);
    int n = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3F000000;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check({nm, "_latency"}, n, 35);
    check({nm, "_data"}, out_data, 32'hC0FFFFFF);
    repeat (4) step();
    check({nm, "_held"}, out_data, 32'hC0FFFFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, "_popped"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n, lows;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);

    // Reset with 10 ops in flight: none may emerge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0;
    repeat (5) step();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (50) step();

    single_op("single");

    // Backpressure: exactly DEPTH accepted.
    n = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = i;
      if (in_ready) n++;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", n, DEPTH);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
    drain();

    // Throughput: in_ready never drops with out_ready held.
    lows = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data = i;
      if (!in_ready) lows++;
      step();
    end
    check("tp_in_ready_lows", lows, 0);
    drain();

    // Flush with 5 buffered and 10 in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0;
    repeat (40) step();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0;
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (60) step();
    single_op("post_flush");

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      in_data   = $urandom;
      step();
    end
    flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
